// File: rtl/weighted_accum_pkg.sv
// Shared types for the weighted_accum slice: FSM state encoding and
// the accumulator width derivation.
package weighted_accum_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } wacc_state_t;

  function automatic int unsigned wacc_sumw(input int unsigned inw,
                                            input int unsigned ww,
                                            input int unsigned cntw);
    return inw + ww + cntw;
  endfunction

endpackage

// File: rtl/wacc_mul_stage.sv
// Registered multiplier stage: one product per accepted beat, with
// valid and last-of-burst flags pipelined alongside it.
module wacc_mul_stage #(
  parameter int unsigned INW = 8,
  parameter int unsigned WW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [INW-1:0]    value,
  input  logic [WW-1:0]     weight,
  input  logic              last,
  output logic [INW+WW-1:0] p,
  output logic              p_vld,
  output logic              p_last
);

  logic [INW+WW-1:0] p_d, p_q;
  logic              p_vld_d, p_vld_q;
  logic              p_last_d, p_last_q;

  always_comb begin
    p_d      = p_q;
    p_vld_d  = accept;
    p_last_d = accept && last;
    if (accept) p_d = (INW+WW)'(value) * (INW+WW)'(weight);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      p_vld_q  <= 1'b0;
      p_last_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      p_vld_q  <= p_vld_d;
      p_last_q <= p_last_d;
    end
  end

  assign p      = p_q;
  assign p_vld  = p_vld_q;
  assign p_last = p_last_q;

endmodule

// File: rtl/weighted_accum.sv
// Burst multiply-accumulate with valid/ready handshakes on both sides.
// Define WEIGHTED_ACCUM_SAT_EN for a saturating accumulator and out_ovf.
module weighted_accum
  import weighted_accum_pkg::*;
#(
  parameter  int unsigned INW  = 8,
  parameter  int unsigned WW   = 8,
  parameter  int unsigned CNTW = 4,
  localparam int unsigned SUMW = wacc_sumw(INW, WW, CNTW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INW-1:0]  in_value,
  input  logic [WW-1:0]   in_weight,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SUMW-1:0] out_sum,
  output logic [CNTW:0]   out_count
`ifdef WEIGHTED_ACCUM_SAT_EN
  , output logic          out_ovf
`endif
);

  localparam logic [CNTW:0] CNT_MAX = (CNTW+1)'(1) << CNTW;

  wacc_state_t       state_d, state_q;
  logic [SUMW-1:0]   acc_d, acc_q;
  logic [CNTW:0]     count_d, count_q;
  logic              in_ready_d, in_ready_q;
  logic              out_valid_d, out_valid_q;
  logic              accept;
  logic [INW+WW-1:0] p;
  logic              p_vld, p_last;
  logic [SUMW-1:0]   addend;
`ifdef WEIGHTED_ACCUM_SAT_EN
  logic [SUMW:0]     sum_ext;
  logic              ovf_d, ovf_q;
`endif

  assign accept = in_valid && in_ready_q;

  wacc_mul_stage #(.INW(INW), .WW(WW)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .value  (in_value),
    .weight (in_weight),
    .last   (in_last),
    .p      (p),
    .p_vld  (p_vld),
    .p_last (p_last)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    addend      = p_vld ? SUMW'(p) : '0;
`ifdef WEIGHTED_ACCUM_SAT_EN
    // Carry out of the widened add pins the sum at all-ones; sticky per burst.
    sum_ext = {1'b0, acc_q} + {1'b0, addend};
    acc_d   = sum_ext[SUMW] ? '1 : sum_ext[SUMW-1:0];
    ovf_d   = ovf_q | sum_ext[SUMW];
`else
    acc_d   = acc_q + addend;
`endif
    if (accept && (count_q != CNT_MAX)) count_d = count_q + (CNTW+1)'(1);

    unique case (state_q)
      ACC: begin
        if (accept && in_last) begin
          state_d    = FLUSH;
          in_ready_d = 1'b0;
        end
      end
      FLUSH: begin
        if (p_last) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
`ifdef WEIGHTED_ACCUM_SAT_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef WEIGHTED_ACCUM_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef WEIGHTED_ACCUM_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = count_q;
`ifdef WEIGHTED_ACCUM_SAT_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
